// File: rtl/rq_pkg.sv
// Shared types and constants for the RQ arbiter slice: FSM state encoding,
// request type codes used for round-robin bookkeeping, and the DWord keep width.
package rq_pkg;

   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_WR_BURST = 1'b1
   } rq_state_t;

   localparam logic RQ_TYPE_WRITE = 1'b1;
   localparam logic RQ_TYPE_READ  = 1'b0;

   localparam int KEEP_W = 8;

endpackage

// File: rtl/rq_tag_pool.sv
// Read tag pool: busy bitmap, lowest-free-index encoder and an allocated-tag
// counter. A tag released this cycle becomes allocatable from the next cycle.
module rq_tag_pool #(
   parameter int NUM_TAGS = 32,
   parameter int TAG_W    = $clog2(NUM_TAGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alloc,
   input  logic             rel_valid,
   input  logic [TAG_W-1:0] rel_tag,
   output logic             tag_free,
   output logic [TAG_W-1:0] free_tag,
   output logic [TAG_W:0]   tags_in_use
);

   logic [NUM_TAGS-1:0] busy;
   logic [NUM_TAGS-1:0] alloc_mask;
   logic [NUM_TAGS-1:0] rel_mask;
   logic                alloc_hit;
   logic                rel_hit;

   // Descending scan so the last assignment wins with the lowest free index.
   always_comb begin
      tag_free = 1'b0;
      free_tag = '0;
      for (int i = NUM_TAGS - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            tag_free = 1'b1;
            free_tag = TAG_W'(i);
         end
      end
   end

   assign alloc_hit = alloc && tag_free;
   assign rel_hit   = rel_valid && busy[rel_tag];

   always_comb begin
      alloc_mask = '0;
      rel_mask   = '0;
      if (alloc_hit) alloc_mask[free_tag] = 1'b1;
      if (rel_hit)   rel_mask[rel_tag]    = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy        <= '0;
         tags_in_use <= '0;
      end else begin
         busy <= (busy & ~rel_mask) | alloc_mask;
         case ({alloc_hit, rel_hit})
            2'b10:   tags_in_use <= tags_in_use + (TAG_W+1)'(1);
            2'b01:   tags_in_use <= tags_in_use - (TAG_W+1)'(1);
            default: tags_in_use <= tags_in_use;
         endcase
      end
   end

endmodule

// File: rtl/rq_arbiter.sv
// Requester-request arbiter between a multi-beat write channel and a single-beat
// read channel, with one output register stage. Define RQ_ARB_WR_PRIORITY_EN for
// strict write-over-read priority; otherwise arbitration is round-robin.
module rq_arbiter
   import rq_pkg::*;
#(
   parameter int DATA_WIDTH = 256,
   parameter int NUM_TAGS   = 32,
   parameter int TAG_W      = $clog2(NUM_TAGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [15:0]           cfg_requester_id,

   input  logic                  wr_valid,
   input  logic                  wr_sop,
   input  logic                  wr_last,
   output logic                  wr_ready,
   input  logic [63:0]           wr_addr,
   input  logic [10:0]           wr_dword_count,
   input  logic [DATA_WIDTH-1:0] wr_payload,
   input  logic [KEEP_W-1:0]     wr_keep,

   input  logic                  rd_valid,
   output logic                  rd_ready,
   input  logic [63:0]           rd_addr,
   input  logic [10:0]           rd_dword_count,
   output logic [TAG_W-1:0]      rd_tag,

   input  logic                  tag_release_valid,
   input  logic [TAG_W-1:0]      tag_release,
   output logic [TAG_W:0]        tags_in_use,

   output logic                  rq_valid,
   output logic                  rq_is_write,
   output logic                  rq_is_read,
   output logic                  rq_sop,
   output logic                  rq_last,
   output logic [63:0]           rq_addr,
   output logic [10:0]           rq_dword_count,
   output logic [7:0]            rq_tag,
   output logic [15:0]           rq_requester_id,
   output logic [2:0]            rq_tc,
   output logic [2:0]            rq_attr,
   output logic [DATA_WIDTH-1:0] rq_payload,
   output logic [KEEP_W-1:0]     rq_payload_keep,
   input  logic                  rq_ready
);

   rq_state_t        state;
   logic             last_grant;
   logic             load;
   logic             tag_free;
   logic [TAG_W-1:0] free_tag;
   logic             wr_elig;
   logic             rd_elig;
   logic             prefer_wr;
   logic             wr_acc;
   logic             rd_acc;

   rq_tag_pool #(
      .NUM_TAGS (NUM_TAGS),
      .TAG_W    (TAG_W)
   ) u_tag_pool (
      .clk         (clk),
      .rst_n       (rst_n),
      .alloc       (rd_acc),
      .rel_valid   (tag_release_valid),
      .rel_tag     (tag_release),
      .tag_free    (tag_free),
      .free_tag    (free_tag),
      .tags_in_use (tags_in_use)
   );

   assign load    = !rq_valid || rq_ready;
   assign wr_elig = wr_valid && wr_sop;
   assign rd_elig = rd_valid && tag_free;
   assign rd_tag  = free_tag;

`ifdef RQ_ARB_WR_PRIORITY_EN
   assign prefer_wr = 1'b1;
`else
   assign prefer_wr = (last_grant == RQ_TYPE_READ);
`endif

   // A losing or tag-starved read never blocks the write channel.
   always_comb begin
      wr_ready = 1'b0;
      rd_ready = 1'b0;
      if (rst_n && load) begin
         if (state == ST_WR_BURST) begin
            wr_ready = 1'b1;
         end else begin
            wr_ready = wr_sop && (!rd_elig || prefer_wr);
            rd_ready = tag_free && !(wr_elig && prefer_wr);
         end
      end
   end

   assign wr_acc  = wr_valid && wr_ready;
   assign rd_acc  = rd_valid && rd_ready;
   assign rq_tc   = 3'b000;
   assign rq_attr = 3'b000;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         last_grant <= RQ_TYPE_READ;
      end else begin
         if (wr_acc) begin
            if (state == ST_IDLE && !wr_last) state <= ST_WR_BURST;
            else if (state == ST_WR_BURST && wr_last) state <= ST_IDLE;
         end
         if (wr_acc && state == ST_IDLE) last_grant <= RQ_TYPE_WRITE;
         else if (rd_acc)                last_grant <= RQ_TYPE_READ;
      end
   end

   // Mid-burst beats keep the address and length captured on the SOP beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rq_valid        <= 1'b0;
         rq_is_write     <= 1'b0;
         rq_is_read      <= 1'b0;
         rq_sop          <= 1'b0;
         rq_last         <= 1'b0;
         rq_addr         <= '0;
         rq_dword_count  <= '0;
         rq_tag          <= '0;
         rq_requester_id <= '0;
         rq_payload      <= '0;
         rq_payload_keep <= '0;
      end else if (load) begin
         rq_valid <= wr_acc || rd_acc;
         if (wr_acc) begin
            rq_is_write     <= 1'b1;
            rq_is_read      <= 1'b0;
            rq_sop          <= wr_sop;
            rq_last         <= wr_last;
            rq_tag          <= 8'h00;
            rq_requester_id <= cfg_requester_id;
            rq_payload      <= wr_payload;
            rq_payload_keep <= wr_keep;
            if (state == ST_IDLE) begin
               rq_addr        <= wr_addr;
               rq_dword_count <= wr_dword_count;
            end
         end else if (rd_acc) begin
            rq_is_write     <= 1'b0;
            rq_is_read      <= 1'b1;
            rq_sop          <= 1'b1;
            rq_last         <= 1'b1;
            rq_addr         <= rd_addr;
            rq_dword_count  <= rd_dword_count;
            rq_tag          <= 8'(free_tag);
            rq_requester_id <= cfg_requester_id;
            rq_payload      <= '0;
            rq_payload_keep <= 8'hFF;
         end
      end
   end

endmodule

// File: tb/tb_rq_arbiter.sv
// Scoreboard bench for rq_arbiter: expected RQ beats are queued when stimulus is
// issued and a negedge monitor pops and compares every beat the formatter takes.
module tb_rq_arbiter;

   localparam logic [15:0] REQ_ID = 16'hBEEF;

   typedef struct {
      logic          is_write;
      logic          sop;
      logic          last;
      logic [63:0]   addr;
      logic [10:0]   dw;
      logic [7:0]    tag;
      logic [255:0]  payload;
      logic [7:0]    keep;
   } beat_t;

   logic         clk;
   logic         rst_n;
   logic         wr_valid, wr_sop, wr_last, wr_ready;
   logic [63:0]  wr_addr;
   logic [10:0]  wr_dword_count;
   logic [255:0] wr_payload;
   logic [7:0]   wr_keep;
   logic         rd_valid, rd_ready;
   logic [63:0]  rd_addr;
   logic [10:0]  rd_dword_count;
   logic [4:0]   rd_tag;
   logic         tag_release_valid;
   logic [4:0]   tag_release;
   logic [5:0]   tags_in_use;
   logic         rq_valid, rq_is_write, rq_is_read, rq_sop, rq_last;
   logic [63:0]  rq_addr;
   logic [10:0]  rq_dword_count;
   logic [7:0]   rq_tag;
   logic [15:0]  rq_requester_id;
   logic [2:0]   rq_tc, rq_attr;
   logic [255:0] rq_payload;
   logic [7:0]   rq_payload_keep;
   logic         rq_ready;

   int    vectors = 0;
   int    miscompares = 0;
   beat_t exp_q[$];
   beat_t mon_e;
   logic [372:0] mon_act, mon_exp;

   rq_arbiter dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .cfg_requester_id  (REQ_ID),
      .wr_valid          (wr_valid),
      .wr_sop            (wr_sop),
      .wr_last           (wr_last),
      .wr_ready          (wr_ready),
      .wr_addr           (wr_addr),
      .wr_dword_count    (wr_dword_count),
      .wr_payload        (wr_payload),
      .wr_keep           (wr_keep),
      .rd_valid          (rd_valid),
      .rd_ready          (rd_ready),
      .rd_addr           (rd_addr),
      .rd_dword_count    (rd_dword_count),
      .rd_tag            (rd_tag),
      .tag_release_valid (tag_release_valid),
      .tag_release       (tag_release),
      .tags_in_use       (tags_in_use),
      .rq_valid          (rq_valid),
      .rq_is_write       (rq_is_write),
      .rq_is_read        (rq_is_read),
      .rq_sop            (rq_sop),
      .rq_last           (rq_last),
      .rq_addr           (rq_addr),
      .rq_dword_count    (rq_dword_count),
      .rq_tag            (rq_tag),
      .rq_requester_id   (rq_requester_id),
      .rq_tc             (rq_tc),
      .rq_attr           (rq_attr),
      .rq_payload        (rq_payload),
      .rq_payload_keep   (rq_payload_keep),
      .rq_ready          (rq_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got simulation still running, need completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, need %h", name, act, exp);
      end
   endtask

   // The formatter takes a beat on any edge where rq_valid && rq_ready.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && rq_valid === 1'b1 && rq_ready === 1'b1) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_beat: got wr=%0b rd=%0b addr=%h tag=%h, need no beat",
                     rq_is_write, rq_is_read, rq_addr, rq_tag);
         end else begin
            mon_e   = exp_q.pop_front();
            mon_act = {rq_is_write, rq_is_read, rq_sop, rq_last, rq_addr, rq_dword_count, rq_tag,
                       rq_payload, rq_payload_keep, rq_tc, rq_attr, rq_requester_id};
            mon_exp = {mon_e.is_write, !mon_e.is_write, mon_e.sop, mon_e.last, mon_e.addr, mon_e.dw,
                       mon_e.tag, mon_e.payload, mon_e.keep, 3'b000, 3'b000, REQ_ID};
            if (mon_act !== mon_exp) begin
               miscompares++;
               $display("[TB] FAIL rq_beat: got wr=%0b rd=%0b sop=%0b last=%0b addr=%h dw=%0d tag=%h keep=%h pl=%h tc=%0d attr=%0d id=%h, need wr=%0b sop=%0b last=%0b addr=%h dw=%0d tag=%h keep=%h pl=%h",
                        rq_is_write, rq_is_read, rq_sop, rq_last, rq_addr, rq_dword_count, rq_tag,
                        rq_payload_keep, rq_payload[63:0], rq_tc, rq_attr, rq_requester_id,
                        mon_e.is_write, mon_e.sop, mon_e.last, mon_e.addr, mon_e.dw, mon_e.tag,
                        mon_e.keep, mon_e.payload[63:0]);
            end
         end
      end
   end

   task automatic pushWrite(input logic sop, input logic last, input logic [63:0] addr,
                            input logic [10:0] dw, input logic [255:0] pl, input logic [7:0] keep);
      beat_t e;
      e.is_write = 1'b1; e.sop = sop; e.last = last; e.addr = addr; e.dw = dw;
      e.tag = 8'h00; e.payload = pl; e.keep = keep;
      exp_q.push_back(e);
   endtask

   task automatic pushRead(input logic [63:0] addr, input logic [10:0] dw, input logic [7:0] tag);
      beat_t e;
      e.is_write = 1'b0; e.sop = 1'b1; e.last = 1'b1; e.addr = addr; e.dw = dw;
      e.tag = tag; e.payload = '0; e.keep = 8'hFF;
      exp_q.push_back(e);
   endtask

   // Stimulus tasks start and end at posedge+1.
   task automatic applyStimulusWrite(input logic sop, input logic last, input logic [63:0] addr,
                                     input logic [10:0] dw, input logic [255:0] pl, input logic [7:0] keep);
      int n;
      wr_valid = 1'b1; wr_sop = sop; wr_last = last; wr_addr = addr;
      wr_dword_count = dw; wr_payload = pl; wr_keep = keep;
      n = 0;
      forever begin
         @(negedge clk);
         if (wr_ready) break;
         n++;
         if (n > 200) begin
            vectors++; miscompares++;
            $display("[TB] FAIL wr_timeout: got no wr handshake, need one within 200 cycles");
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      wr_valid = 1'b0; wr_sop = 1'b0; wr_last = 1'b0;
   endtask

   task automatic applyStimulusRead(input logic [63:0] addr, input logic [10:0] dw, input logic [4:0] exp_tag);
      int n;
      rd_valid = 1'b1; rd_addr = addr; rd_dword_count = dw;
      n = 0;
      forever begin
         @(negedge clk);
         if (rd_ready) begin
            checkOutput("rd_tag", 64'(rd_tag), 64'(exp_tag));
            break;
         end
         n++;
         if (n > 200) begin
            vectors++; miscompares++;
            $display("[TB] FAIL rd_timeout: got no rd handshake, need one within 200 cycles");
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      rd_valid = 1'b0;
   endtask

   task automatic applyStimulusRelease(input logic [4:0] t);
      tag_release_valid = 1'b1; tag_release = t;
      @(posedge clk); #1;
      tag_release_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("drain_left", 64'(exp_q.size()), 64'd0);
   endtask

   logic [63:0] snap_pl;
   logic [2:0]  snap_ctl;

   initial begin
      rst_n = 1'b0; rq_ready = 1'b1;
      wr_valid = 1'b1; wr_sop = 1'b1; wr_last = 1'b0; wr_addr = '0; wr_dword_count = '0;
      wr_payload = '0; wr_keep = '0;
      rd_valid = 1'b1; rd_addr = '0; rd_dword_count = '0;
      tag_release_valid = 1'b0; tag_release = '0;

      // Reset state, with both channels requesting.
      #2;
      checkOutput("rst_rq_valid", 64'(rq_valid), 64'd0);
      checkOutput("rst_wr_ready", 64'(wr_ready), 64'd0);
      checkOutput("rst_rd_ready", 64'(rd_ready), 64'd0);
      checkOutput("rst_tags_in_use", 64'(tags_in_use), 64'd0);
      checkOutput("rst_rq_addr", rq_addr, 64'd0);
      wr_valid = 1'b0; wr_sop = 1'b0; rd_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Single reads: first tag 0, next tag 1.
      pushRead(64'h7F80_0000, 11'd4, 8'h00);
      applyStimulusRead(64'h7F80_0000, 11'd4, 5'd0);
      pushRead(64'h0000_1000, 11'd1, 8'h01);
      applyStimulusRead(64'h0000_1000, 11'd1, 5'd1);
      drain();
      checkOutput("tags_after_2rd", 64'(tags_in_use), 64'd2);
      applyStimulusRelease(5'd0);
      applyStimulusRelease(5'd1);
      checkOutput("tags_after_rel", 64'(tags_in_use), 64'd0);

      // 3-beat write with a read pending: write beats contiguous, then read.
      pushWrite(1'b1, 1'b0, 64'h2000_0000, 11'd24, 256'h11, 8'hFF);
      pushWrite(1'b0, 1'b0, 64'h2000_0000, 11'd24, 256'h22, 8'hFF);
      pushWrite(1'b0, 1'b1, 64'h2000_0000, 11'd24, 256'h33, 8'h0F);
      pushRead(64'h0000_3000, 11'd2, 8'h00);
      fork
         begin
            applyStimulusWrite(1'b1, 1'b0, 64'h2000_0000, 11'd24, 256'h11, 8'hFF);
            applyStimulusWrite(1'b0, 1'b0, 64'hDEAD, 11'h7FF, 256'h22, 8'hFF);
            applyStimulusWrite(1'b0, 1'b1, 64'hBEEF, 11'h7FF, 256'h33, 8'h0F);
         end
         applyStimulusRead(64'h0000_3000, 11'd2, 5'd0);
      join
      drain();
      applyStimulusRelease(5'd0);

      // Both channels continuously eligible.
`ifdef RQ_ARB_WR_PRIORITY_EN
      for (int i = 0; i < 4; i++)
         pushWrite(1'b1, 1'b1, 64'h4000 + 64'(i) * 64'h100, 11'd1, 256'(i + 1), 8'h01);
      for (int i = 0; i < 4; i++)
         pushRead(64'h5000 + 64'(i), 11'd1, 8'(i));
`else
      for (int i = 0; i < 4; i++) begin
         pushWrite(1'b1, 1'b1, 64'h4000 + 64'(i) * 64'h100, 11'd1, 256'(i + 1), 8'h01);
         pushRead(64'h5000 + 64'(i), 11'd1, 8'(i));
      end
`endif
      fork
         for (int i = 0; i < 4; i++)
            applyStimulusWrite(1'b1, 1'b1, 64'h4000 + 64'(i) * 64'h100, 11'd1, 256'(i + 1), 8'h01);
         for (int j = 0; j < 4; j++)
            applyStimulusRead(64'h5000 + 64'(j), 11'd1, 5'(j));
      join
      drain();
      for (int i = 0; i < 4; i++) applyStimulusRelease(5'(i));
      checkOutput("tags_after_alt", 64'(tags_in_use), 64'd0);

      // Exhaust the pool.
      for (int i = 0; i < 32; i++) begin
         pushRead(64'h8000 + 64'(i) * 64'h40, 11'd1, 8'(i));
         applyStimulusRead(64'h8000 + 64'(i) * 64'h40, 11'd1, 5'(i));
      end
      drain();
      checkOutput("tags_full", 64'(tags_in_use), 64'd32);
      rd_valid = 1'b1;
      @(negedge clk);
      checkOutput("rd_ready_full", 64'(rd_ready), 64'd0);
      @(posedge clk); #1;
      pushWrite(1'b1, 1'b1, 64'hA000, 11'd1, 256'hA1, 8'h01);
      pushWrite(1'b1, 1'b1, 64'hA100, 11'd1, 256'hA2, 8'h03);
      applyStimulusWrite(1'b1, 1'b1, 64'hA000, 11'd1, 256'hA1, 8'h01);
      applyStimulusWrite(1'b1, 1'b1, 64'hA100, 11'd1, 256'hA2, 8'h03);
      rd_valid = 1'b0;
      drain();
      applyStimulusRelease(5'd5);
      checkOutput("tags_rel5", 64'(tags_in_use), 64'd31);
      applyStimulusRelease(5'd5);
      checkOutput("tags_rel5_again", 64'(tags_in_use), 64'd31);
      pushRead(64'hB000, 11'd3, 8'h05);
      applyStimulusRead(64'hB000, 11'd3, 5'd5);
      checkOutput("tags_realloc5", 64'(tags_in_use), 64'd32);
      applyStimulusRelease(5'd6);
      pushRead(64'hB100, 11'd1, 8'h06);
      fork
         applyStimulusRead(64'hB100, 11'd1, 5'd6);
         applyStimulusRelease(5'd7);
      join
      checkOutput("tags_alloc_rel", 64'(tags_in_use), 64'd31);
      pushRead(64'hB200, 11'd1, 8'h07);
      applyStimulusRead(64'hB200, 11'd1, 5'd7);
      checkOutput("tags_full_again", 64'(tags_in_use), 64'd32);
      drain();
      for (int i = 0; i < 32; i++) applyStimulusRelease(5'(i));
      checkOutput("tags_empty", 64'(tags_in_use), 64'd0);

      // Formatter backpressure for 4 cycles in the middle of a burst.
      pushWrite(1'b1, 1'b0, 64'hC000, 11'd32, 256'hC1, 8'hFF);
      pushWrite(1'b0, 1'b0, 64'hC000, 11'd32, 256'hC2, 8'hFF);
      pushWrite(1'b0, 1'b0, 64'hC000, 11'd32, 256'hC3, 8'hFF);
      pushWrite(1'b0, 1'b1, 64'hC000, 11'd32, 256'hC4, 8'h3F);
      fork
         begin
            applyStimulusWrite(1'b1, 1'b0, 64'hC000, 11'd32, 256'hC1, 8'hFF);
            applyStimulusWrite(1'b0, 1'b0, 64'h0, 11'd0, 256'hC2, 8'hFF);
            applyStimulusWrite(1'b0, 1'b0, 64'h0, 11'd0, 256'hC3, 8'hFF);
            applyStimulusWrite(1'b0, 1'b1, 64'h0, 11'd0, 256'hC4, 8'h3F);
         end
         begin
            repeat (3) @(posedge clk);
            #1 rq_ready = 1'b0;
            @(negedge clk);
            snap_pl  = rq_payload[63:0];
            snap_ctl = {rq_sop, rq_last, rq_is_write};
            checkOutput("stall_valid", 64'(rq_valid), 64'd1);
            repeat (3) begin
               @(negedge clk);
               checkOutput("stall_payload", rq_payload[63:0], snap_pl);
               checkOutput("stall_ctl", 64'({rq_sop, rq_last, rq_is_write}), 64'(snap_ctl));
            end
            @(posedge clk); #1 rq_ready = 1'b1;
         end
      join
      drain();

      // Reset in the middle of a write burst with one tag held.
      pushRead(64'h9000, 11'd1, 8'h00);
      applyStimulusRead(64'h9000, 11'd1, 5'd0);
      pushWrite(1'b1, 1'b0, 64'hD000, 11'd16, 256'hD1, 8'hFF);
      applyStimulusWrite(1'b1, 1'b0, 64'hD000, 11'd16, 256'hD1, 8'hFF);
      applyStimulusWrite(1'b0, 1'b0, 64'h0, 11'd0, 256'hD2, 8'hFF);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_rq_valid", 64'(rq_valid), 64'd0);
      checkOutput("midrst_tags", 64'(tags_in_use), 64'd0);
      checkOutput("midrst_left", 64'(exp_q.size()), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      wr_valid = 1'b1; wr_sop = 1'b0; wr_last = 1'b1;
      @(negedge clk);
      checkOutput("idle_nosop_stall", 64'(wr_ready), 64'd0);
      @(posedge clk); #1;
      wr_valid = 1'b0; wr_last = 1'b0;
      pushWrite(1'b1, 1'b1, 64'hE000, 11'd1, 256'hE1, 8'h01);
      pushRead(64'hE100, 11'd1, 8'h00);
      fork
         applyStimulusWrite(1'b1, 1'b1, 64'hE000, 11'd1, 256'hE1, 8'h01);
         applyStimulusRead(64'hE100, 11'd1, 5'd0);
      join
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rq_arbiter.md
RQ_ARBITER -- requirements
Module: rq_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 256, is the RQ datapath width in bits; it is fixed at 256.
REQ-002 Parameter NUM_TAGS, default 32, is the read tag pool size (power of two, 2..256); TAG_W = clog2(NUM_TAGS).
REQ-003 clk  in  1  core clock; all logic is on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 cfg_requester_id  in  16  Bus:Dev:Func, copied to rq_requester_id.
REQ-006 wr_valid, wr_sop, wr_last  in  1 each  write channel beat qualifiers.
REQ-007 wr_ready  out  1  write beat accepted when wr_valid && wr_ready.
REQ-008 wr_addr  in  64; wr_dword_count  in  11  write descriptor, sampled on the SOP beat.
REQ-009 wr_payload  in  256; wr_keep  in  8  write data and DWord enables.
REQ-010 rd_valid  in  1; rd_ready  out  1  single-beat read request handshake.
REQ-011 rd_addr  in  64; rd_dword_count  in  11  read descriptor.
REQ-012 rd_tag  out  TAG_W  tag allocated to the read accepted in the same cycle.
REQ-013 tag_release_valid  in  1; tag_release  in  TAG_W  completion logic frees a tag.
REQ-014 tags_in_use  out  TAG_W+1  count of allocated tags.
REQ-015 rq_valid, rq_is_write, rq_is_read, rq_sop, rq_last  out  1 each  to the RQ formatter.
REQ-016 rq_addr 64, rq_dword_count 11, rq_tag 8, rq_requester_id 16, rq_tc 3, rq_attr 3, rq_payload 256, rq_payload_keep 8  out  to the RQ formatter.
REQ-017 rq_ready  in  1  formatter ready.

Function
REQ-018 Outputs rq_* SHALL be driven from a single register stage; latency from accepted input beat to rq_valid is 1 cycle.
REQ-019 The stage SHALL load when empty or when rq_valid && rq_ready (full throughput, no bubble); rq_* SHALL hold steady while rq_valid && !rq_ready.
REQ-020 The FSM states SHALL be IDLE and WR_BURST.
REQ-021 In IDLE, arbitration SHALL be eligible between a write SOP beat (wr_valid && wr_sop) and a read (rd_valid && a tag is free).
REQ-022 Arbitration SHALL be round-robin: when both are eligible, the channel not granted last SHALL win; last_grant resets to read, so write wins first.
REQ-023 On a write SOP grant with !wr_last, the FSM SHALL go to WR_BURST and grant only write beats until the wr_last beat is accepted, then return to IDLE.
REQ-024 In IDLE, a write beat with wr_sop=0 SHALL be stalled (wr_ready=0), never forwarded.
REQ-025 Reads SHALL be emitted with rq_is_read=1, rq_sop=1, rq_last=1, rq_payload=0, rq_payload_keep=8'hFF, and rq_tag={zero-pad, allocated tag}.
REQ-026 Writes SHALL be emitted with rq_is_write=1 and rq_tag=8'h00; rq_sop/rq_last/payload/keep SHALL be copied from the write beat.
REQ-027 rq_tc and rq_attr SHALL be 0; rq_is_write and rq_is_read SHALL never both be 1.
REQ-028 The tag pool SHALL be a NUM_TAGS-bit busy bitmap; allocation SHALL pick the lowest free index, and rd_tag SHALL be valid in the rd_valid && rd_ready cycle.
REQ-029 When all tags are busy, rd_ready SHALL be 0 and the write channel SHALL be served regardless of round-robin order.
REQ-030 A release of a busy tag SHALL clear it next cycle; a release of a non-busy tag SHALL be ignored.
REQ-031 An allocation and a release in the same cycle SHALL both take effect; tags_in_use SHALL change by net 0.
REQ-032 A released tag SHALL be allocatable no earlier than the following cycle.

Reset
REQ-033 On rst_n low: FSM=IDLE, rq_valid=0, all rq_* data=0, bitmap clear, tags_in_use=0, last_grant=read, wr_ready=rd_ready=0.
REQ-034 Reset during WR_BURST SHALL discard the partial TLP; the upstream is reset with it.

Configuration
REQ-035 With macro RQ_ARB_WR_PRIORITY_EN defined, arbitration in IDLE SHALL be strict write-over-read priority instead of REQ-022.
REQ-036 With RQ_ARB_WR_PRIORITY_EN undefined, arbitration SHALL be round-robin per REQ-022.

Structure
REQ-037 Package rq_pkg SHALL hold the FSM state enum, RQ_TYPE_WRITE/RQ_TYPE_READ constants, and the 8-DWord keep width.
REQ-038 Sub-module rq_tag_pool SHALL implement the bitmap, lowest-free encoder, and tags_in_use counter.

Verification
REQ-039 Read only, rd_addr=0x7F80_0000, dword_count=4, rq_ready=1 -> one beat, rq_is_read=1, rq_tag=0x00, next read gets tag 0x01.
REQ-040 3-beat write (sop, mid, last keep=0x0F) with a read pending throughout -> the 3 write beats are contiguous, then the read follows.
REQ-041 Both channels continuously eligible -> grants alternate W,R,W,R; with RQ_ARB_WR_PRIORITY_EN, reads never win while writes are eligible.
REQ-042 32 reads with no release -> tags_in_use=32, rd_ready=0; release tag 5 -> next read gets tag 5.
REQ-043 rq_ready=0 for 4 cycles mid-burst -> rq_* stable, no beat lost or duplicated.
REQ-044 rst_n asserted mid-WR_BURST -> rq_valid=0 immediately, FSM=IDLE, tags_in_use=0.
